// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor shared definitions:
// state encoding and bit-counter sizing.
package serial_subtractor_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand and result handshakes of the
// bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero
  );

endinterface

// File: rtl/serial_subtractor_cell.sv
// Half and full subtractor cells, shaped
// like the ripple full-adder cell.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bout
);

  assign d    = x ^ y;
  assign bout = ~x & y;

endmodule

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d1;
  logic b1;
  logic b2;

  half_subtractor u_hs1 (
    .x    (x),
    .y    (y),
    .d    (d1),
    .bout (b1)
  );

  half_subtractor u_hs2 (
    .x    (d1),
    .y    (bin),
    .d    (d),
    .bout (b2)
  );

  assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first,
// one full-subtractor cell and a borrow flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             bout_q;
  logic             zero_q;
  logic             rdy_q;
  logic             d;
  logic             bo;
  logic             accept;

  full_subtractor u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bo)
  );

  // res keeps only the upper bits; the new bit completes it
  assign res_full = {d, res};
  assign accept   = rdy_q & bus.in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      diff_q <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == S_IDLE): begin
          rdy_q <= ~accept;
          if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            borrow <= bus.bin;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        (state == S_RUN): begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res    <= res_full[WIDTH-1:1];
          borrow <= bo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff_q <= res_full;
            bout_q <= bo;
            zero_q <= ~|res_full;
            state  <= S_DONE;
          end
        end
        (state == S_DONE): begin
          if (bus.out_ready) begin
            rdy_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = (state == S_DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases plus
// random regression at WIDTH 8 and 2 against a model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int edges = 0;
  int done8 = 0;
  int done2 = 0;
  bit rnd8 = 1'b0;
  bit rnd2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  serial_subtractor_if #(.WIDTH(8)) b8 ();
  serial_subtractor_if #(.WIDTH(2)) b2 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  typedef struct {
    logic [32:0] r;
    int          e;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];

  // {bout, diff} is the (WIDTH+1)-bit two's-complement difference
  function automatic logic [32:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic bi);
    longint t;
    logic [32:0] m;
    t = longint'(a) - longint'(b) - (bi ? 64'sd1 : 64'sd0);
    m = (33'd1 << (w + 1)) - 33'd1;
    return 33'(t) & m;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  initial begin : mon8
    logic pv;
    logic [9:0] held;
    exp_t x;
    pv = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q8.delete();
        pv = 1'b0;
      end else begin
        if (b8.out_valid) begin
          chk("busy_ready8", 64'(b8.in_ready), 64'd0);
          if (!pv) begin
            if (q8.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious8: out_valid with diff %0h, none pending",
                       b8.diff);
            end else begin
              x = q8.pop_front();
              chk("diff8", 64'(b8.diff), 64'(x.r[7:0]));
              chk("bout8", 64'(b8.bout), 64'(x.r[8]));
              chk("zero8", 64'(b8.zero), 64'(x.r[7:0] == 8'd0));
              chk("lat8", 64'(edges - x.e), 64'd8);
              done8++;
            end
            held = {b8.zero, b8.bout, b8.diff};
          end else begin
            chk("hold8", 64'({b8.zero, b8.bout, b8.diff}), 64'(held));
          end
        end
        if (b8.in_valid && b8.in_ready) begin
          x.r = model(8, 32'(b8.a), 32'(b8.b), b8.bin);
          x.e = edges + 1;
          q8.push_back(x);
        end
        pv = b8.out_valid;
      end
    end
  end

  initial begin : mon2
    logic pv;
    logic [3:0] held;
    exp_t x;
    pv = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q2.delete();
        pv = 1'b0;
      end else begin
        if (b2.out_valid) begin
          chk("busy_ready2", 64'(b2.in_ready), 64'd0);
          if (!pv) begin
            if (q2.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious2: out_valid with diff %0h, none pending",
                       b2.diff);
            end else begin
              x = q2.pop_front();
              chk("diff2", 64'(b2.diff), 64'(x.r[1:0]));
              chk("bout2", 64'(b2.bout), 64'(x.r[2]));
              chk("zero2", 64'(b2.zero), 64'(x.r[1:0] == 2'd0));
              chk("lat2", 64'(edges - x.e), 64'd2);
              done2++;
            end
            held = {b2.zero, b2.bout, b2.diff};
          end else begin
            chk("hold2", 64'({b2.zero, b2.bout, b2.diff}), 64'(held));
          end
        end
        if (b2.in_valid && b2.in_ready) begin
          x.r = model(2, 32'(b2.a), 32'(b2.b), b2.bin);
          x.e = edges + 1;
          q2.push_back(x);
        end
        pv = b2.out_valid;
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b,
                       input logic bi);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    b8.a = a;
    b8.b = b;
    b8.bin = bi;
    b8.in_valid = 1'b1;
    @(negedge clk);
    while (!b8.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b8.in_ready) chk("accept_to8", 64'(b8.in_ready), 64'd1);
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    b8.a = 8'($urandom);
    b8.b = 8'($urandom);
    b8.bin = 1'($urandom);
  endtask

  task automatic send2(input logic [1:0] a, input logic [1:0] b,
                       input logic bi);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    b2.a = a;
    b2.b = b;
    b2.bin = bi;
    b2.in_valid = 1'b1;
    @(negedge clk);
    while (!b2.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b2.in_ready) chk("accept_to2", 64'(b2.in_ready), 64'd1);
    @(posedge clk);
    #1;
    b2.in_valid = 1'b0;
    b2.a = 2'($urandom);
    b2.b = 2'($urandom);
    b2.bin = 1'($urandom);
  endtask

  task automatic wait_ov8(output int n);
    n = 0;
    @(negedge clk);
    while (!b8.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!b8.out_valid) chk("result_to8", 64'(b8.out_valid), 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic bi, input logic [7:0] ed,
                     input logic eb, input logic ez, input string nm);
    int n;
    b8.out_ready = 1'b1;
    send8(a, b, bi);
    wait_ov8(n);
    chk({nm, "_lat"}, 64'(n), 64'd8);
    chk({nm, "_diff"}, 64'(b8.diff), 64'(ed));
    chk({nm, "_bout"}, 64'(b8.bout), 64'(eb));
    chk({nm, "_zero"}, 64'(b8.zero), 64'(ez));
    @(negedge clk);
    chk({nm, "_pulse"}, 64'(b8.out_valid), 64'd0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int d0;
    b8.in_valid = 1'b0;
    b8.a = '0;
    b8.b = '0;
    b8.bin = 1'b0;
    b8.out_ready = 1'b0;
    b2.in_valid = 1'b0;
    b2.a = '0;
    b2.b = '0;
    b2.bin = 1'b0;
    b2.out_ready = 1'b0;

    chk("model_35_12", 64'(model(8, 32'h35, 32'h12, 1'b0)), 64'h023);
    chk("model_12_35", 64'(model(8, 32'h12, 32'h35, 1'b0)), 64'h1DD);
    chk("model_0_0_1", 64'(model(8, 32'h00, 32'h00, 1'b1)), 64'h1FF);
    chk("model_w2", 64'(model(2, 32'h1, 32'h2, 1'b1)), 64'h6);

    #12;
    chk("rst_ready", 64'(b8.in_ready), 64'd0);
    chk("rst_valid", 64'(b8.out_valid), 64'd0);
    chk("rst_diff", 64'(b8.diff), 64'd0);
    chk("rst_bout", 64'(b8.bout), 64'd0);
    chk("rst_zero", 64'(b8.zero), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_pre_edge", 64'(b8.in_ready), 64'd0);
    @(negedge clk);
    chk("ready_post_edge", 64'(b8.in_ready), 64'd1);

    op8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, "t1");
    op8(8'h12, 8'h35, 1'b0, 8'hDD, 1'b1, 1'b0, "t2");
    op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "t3a");
    op8(8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, "t3b");

    b8.out_ready = 1'b0;
    send8(8'h77, 8'h11, 1'b0);
    wait_ov8(n);
    chk("t4_diff", 64'(b8.diff), 64'h66);
    @(posedge clk);
    #1;
    b8.a = 8'h40;
    b8.b = 8'h01;
    b8.bin = 1'b1;
    b8.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_valid", 64'(b8.out_valid), 64'd1);
      chk("t4_ready", 64'(b8.in_ready), 64'd0);
      chk("t4_hold", 64'(b8.diff), 64'h66);
    end
    @(posedge clk);
    #1;
    b8.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_idle_valid", 64'(b8.out_valid), 64'd0);
    chk("t4_idle_ready", 64'(b8.in_ready), 64'd1);
    @(posedge clk);
    #1;
    b8.in_valid = 1'b0;
    wait_ov8(n);
    chk("t4_new_lat", 64'(n), 64'd8);
    chk("t4_new_diff", 64'(b8.diff), 64'h3E);
    chk("t4_new_bout", 64'(b8.bout), 64'd0);

    send8(8'hF0, 8'h0F, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 64'(b8.out_valid), 64'd0);
    chk("t5_diff", 64'(b8.diff), 64'd0);
    chk("t5_bout", 64'(b8.bout), 64'd0);
    chk("t5_zero", 64'(b8.zero), 64'd0);
    chk("t5_ready", 64'(b8.in_ready), 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op8(8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 1'b0, "t5");

    d0 = done8;
    rnd8 = 1'b1;
    rnd2 = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send8(8'($urandom), 8'($urandom), 1'($urandom));
        rnd8 = 1'b0;
      end
      begin
        for (int i = 0; i < 1000; i++)
          send2(2'($urandom), 2'($urandom), 1'($urandom));
        rnd2 = 1'b0;
      end
      begin
        while (rnd8) begin
          @(posedge clk);
          #1;
          b8.out_ready = ($urandom_range(0, 2) != 0);
        end
        b8.out_ready = 1'b1;
      end
      begin
        while (rnd2) begin
          @(posedge clk);
          #1;
          b2.out_ready = ($urandom_range(0, 2) != 0);
        end
        b2.out_ready = 1'b1;
      end
    join
    repeat (30) @(negedge clk);
    chk("sb8_empty", 64'(q8.size()), 64'd0);
    chk("sb2_empty", 64'(q2.size()), 64'd0);
    chk("rand8_count", 64'(done8 - d0), 64'd1000);
    chk("rand2_count", 64'(done2), 64'd1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
